updown_count_monitor: RTL and testbench
=======================================

Name: updown_count_monitor

Overview:
- Receive-side checker for the 4-bit synchronous up/down counter output.
- Samples the counter value each enabled cycle, infers the count direction, and flags wrap-around events, direction reversals and illegal steps (skips or jumps).
- Sits downstream of the counter in the lab test harness and provides a self-checking observer.
- Direction encoding matches the counter's control input: 0 = up, 1 = down.

Parameters:
- WIDTH, 4, width of the monitored count value.
- ERRW, 8, width of the saturating illegal-step counter.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- rst  input  1  asynchronous active-high reset.
- count_in  input  WIDTH  counter value being monitored.
- sample_en  input  1  count_in is sampled on this rising edge when high.
- dir  output  1  inferred direction (0 up, 1 down); meaningful only while locked=1.
- locked  output  1  high while the FSM is in LOCKED.
- wrap  output  1  one-cycle pulse on a legal wrap (max->0 counting up, 0->max counting down).
- dir_change  output  1  one-cycle pulse when a locked stream reverses direction.
- step_err  output  1  one-cycle pulse on an illegal step.
- err_count  output  ERRW  count of step_err pulses since reset; saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, prev=0, dir=0, locked=0, wrap=0, dir_change=0, step_err=0, err_count=0. Reset asserted mid-stream discards all history immediately.
- All outputs are registered. Events appear the cycle after the sampling edge.
- wrap, dir_change and step_err are low on any cycle without a qualifying sample. They never stay high for two consecutive cycles unless qualifying samples occur on consecutive edges.
- delta = (count_in - prev) mod 2^WIDTH. UP step: delta=1. DOWN step: delta=2^WIDTH-1. HOLD: delta=0.
- Every accepted sample updates prev to count_in, in all states and cases.
- sample_en=0: no state change, prev held, no pulses.
- FSM states and transitions:
  - IDLE, on sample: store prev, go to TRAIN. No pulses.
  - TRAIN, on sample:
    - UP: dir=0, go to LOCKED.
    - DOWN: dir=1, go to LOCKED.
    - HOLD: stay in TRAIN.
    - Other delta: step_err=1, stay in TRAIN.
    - A wrap step during TRAIN (e.g. max->0) locks but does not pulse wrap.
  - LOCKED, on sample:
    - HOLD: no event.
    - Step in the current dir: legal. If it is a wrap (up: prev=max, count_in=0; down: prev=0, count_in=max), pulse wrap=1.
    - Step opposite to dir: toggle dir, pulse dir_change=1, stay in LOCKED. If that reversing step is itself a wrap, pulse wrap as well.
    - Other delta: step_err=1, locked drops, go to TRAIN. dir holds its last value.
- Jumps to 0 or max (counter load/clear events) count as illegal steps unless the delta equals UP or DOWN.
- err_count increments on each step_err pulse, saturates at 2^ERRW-1, and is cleared only by rst.
- Samples on consecutive cycles are fully supported: sustained throughput of one sample per clock, no stalls.

Test Plan:
- Reset then sample 3,4,5,6 -> locked=1 after the 2nd sample's edge; dir=0; no wrap, step_err or dir_change; err_count=0.
- Locked up stream 14,15,0,1 -> wrap=1 for exactly one cycle, following the 15->0 sample; dir stays 0.
- Sample 5,4,3 then 4 -> dir=1 locked. On sample 4: dir_change=1 for one cycle, dir=0, locked stays 1. Down wrap 1,0,15 -> wrap pulse.
- Locked up at 7, then sample 12 -> step_err=1, err_count=1, locked=0. Next samples 13,14 -> relock with dir=0 after 13.
- Sample 6, then 6 repeated 5 times with sample_en=1, then 7 -> no pulses during holds; locks up on the 7. Toggling sample_en=0 between samples changes nothing.
- Assert rst asynchronously mid-cycle while locked with err_count=3 -> all outputs 0 immediately, before the next clock edge. First sample after release returns to TRAIN with no pulse. Also force 300 illegal steps -> err_count holds at 255.

Source files
------------

// File: rtl/updown_count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : updown_count_monitor
// Purpose  : Observes a WIDTH-bit up/down counter. Infers its direction and
//            flags legal wraps, direction reversals and illegal steps.
// Revision : 1.0 - initial release
// ============================================================================
module updown_count_monitor #(
    parameter int WIDTH = 4,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             sample_en,
    output logic             dir,
    output logic             locked,
    output logic             wrap,
    output logic             dir_change,
    output logic             step_err,
    output logic [ERRW-1:0]  err_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRAIN  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_zero  = '0;
    localparam logic [WIDTH-1:0] c_one   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_max   = '1;
    localparam logic [ERRW-1:0]  c_esat  = '1;
    localparam logic [ERRW-1:0]  c_eone  = {{(ERRW-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             dirchg_q, dirchg_d;
    logic             steperr_q, steperr_d;
    logic [ERRW-1:0]  errcnt_q, errcnt_d;

    logic [WIDTH-1:0] w_delta;
    logic             w_is_up;
    logic             w_is_down;
    logic             w_is_hold;
    logic             w_up_wrap;
    logic             w_down_wrap;

    // Modular difference: a max->0 up step and a 0->max down step both
    // land on the ordinary +1 / -1 codes, so wraps need no special case here.
    assign w_delta     = count_in - prev_q;
    assign w_is_up     = (w_delta == c_one);
    assign w_is_down   = (w_delta == c_max);
    assign w_is_hold   = (w_delta == c_zero);
    assign w_up_wrap   = (prev_q == c_max)  && (count_in == c_zero);
    assign w_down_wrap = (prev_q == c_zero) && (count_in == c_max);

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        dir_d     = dir_q;
        wrap_d    = 1'b0;
        dirchg_d  = 1'b0;
        steperr_d = 1'b0;

        if (sample_en) begin
            prev_d = count_in;
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_TRAIN;
                end
                S_TRAIN: begin
                    if (w_is_up) begin
                        dir_d   = 1'b0;
                        state_d = S_LOCKED;
                    end else if (w_is_down) begin
                        dir_d   = 1'b1;
                        state_d = S_LOCKED;
                    end else if (!w_is_hold) begin
                        steperr_d = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (w_is_up) begin
                        wrap_d = w_up_wrap;
                        if (dir_q) begin
                            dir_d    = 1'b0;
                            dirchg_d = 1'b1;
                        end
                    end else if (w_is_down) begin
                        wrap_d = w_down_wrap;
                        if (!dir_q) begin
                            dir_d    = 1'b1;
                            dirchg_d = 1'b1;
                        end
                    end else if (!w_is_hold) begin
                        steperr_d = 1'b1;
                        state_d   = S_TRAIN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        errcnt_d = errcnt_q;
        if (steperr_d && (errcnt_q != c_esat)) begin
            errcnt_d = errcnt_q + c_eone;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            prev_q    <= '0;
            dir_q     <= 1'b0;
            wrap_q    <= 1'b0;
            dirchg_q  <= 1'b0;
            steperr_q <= 1'b0;
            errcnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            dir_q     <= dir_d;
            wrap_q    <= wrap_d;
            dirchg_q  <= dirchg_d;
            steperr_q <= steperr_d;
            errcnt_q  <= errcnt_d;
        end
    end

    assign dir        = dir_q;
    assign locked     = (state_q == S_LOCKED);
    assign wrap       = wrap_q;
    assign dir_change = dirchg_q;
    assign step_err   = steperr_q;
    assign err_count  = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_count_monitor
// Purpose  : Directed self-checking bench for updown_count_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_count_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] count_in;
    logic       sample_en;
    logic       dir;
    logic       locked;
    logic       wrap;
    logic       dir_change;
    logic       step_err;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    updown_count_monitor #(.WIDTH(4), .ERRW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .sample_en  (sample_en),
        .dir        (dir),
        .locked     (locked),
        .wrap       (wrap),
        .dir_change (dir_change),
        .step_err   (step_err),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst       = 1'b1;
        sample_en = 1'b0;
        count_in  = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present one sample on the next edge; outputs are observed 1 time unit later.
    task automatic samp(input logic [3:0] v);
        count_in  = v;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    // Packed outputs: {locked, dir, wrap, dir_change, step_err}
    task automatic test_reset();
        rst = 1'b1; sample_en = 1'b0; count_in = 4'd0;
        #2;
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=00000", {locked, dir, wrap, dir_change, step_err});
        end
        n_checks++;
        if (err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_errcnt got=%0d exp=0", err_count);
        end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_lock_up();
        apply_reset();
        samp(4'd3);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err} !== 5'b00000) begin
            n_fail++;
            $display("FAIL lockup_first got=%b exp=00000", {locked, dir, wrap, dir_change, step_err});
        end
        samp(4'd4);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL lockup_second got=%b exp=10000", {locked, dir, wrap, dir_change, step_err});
        end
        samp(4'd5);
        samp(4'd6);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err, err_count} !== {5'b10000, 8'd0}) begin
            n_fail++;
            $display("FAIL lockup_fourth got=%b/%0d exp=10000/0", {locked, dir, wrap, dir_change, step_err}, err_count);
        end
    endtask

    task automatic test_up_wrap();
        apply_reset();
        samp(4'd13);
        samp(4'd14);
        samp(4'd15);
        n_checks++;
        if (wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL upwrap_pre got=%b exp=0", wrap);
        end
        samp(4'd0);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err} !== 5'b10100) begin
            n_fail++;
            $display("FAIL upwrap_pulse got=%b exp=10100", {locked, dir, wrap, dir_change, step_err});
        end
        samp(4'd1);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL upwrap_after got=%b exp=10000", {locked, dir, wrap, dir_change, step_err});
        end
    endtask

    task automatic test_dir_change();
        apply_reset();
        samp(4'd5);
        samp(4'd4);
        n_checks++;
        if ({locked, dir} !== 2'b11) begin
            n_fail++;
            $display("FAIL dchg_lockdown got=%b exp=11", {locked, dir});
        end
        samp(4'd3);
        samp(4'd4);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err} !== 5'b10010) begin
            n_fail++;
            $display("FAIL dchg_pulse got=%b exp=10010", {locked, dir, wrap, dir_change, step_err});
        end
        samp(4'd5);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL dchg_after got=%b exp=10000", {locked, dir, wrap, dir_change, step_err});
        end
        // down wrap, then a reversal that is itself an up wrap
        apply_reset();
        samp(4'd2);
        samp(4'd1);
        samp(4'd0);
        n_checks++;
        if (wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL dnwrap_pre got=%b exp=0", wrap);
        end
        samp(4'd15);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err} !== 5'b11100) begin
            n_fail++;
            $display("FAIL dnwrap_pulse got=%b exp=11100", {locked, dir, wrap, dir_change, step_err});
        end
        samp(4'd0);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err} !== 5'b10110) begin
            n_fail++;
            $display("FAIL revwrap got=%b exp=10110", {locked, dir, wrap, dir_change, step_err});
        end
        // wrap step while training locks without a wrap pulse
        apply_reset();
        samp(4'd15);
        samp(4'd0);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL trainwrap got=%b exp=10000", {locked, dir, wrap, dir_change, step_err});
        end
    endtask

    task automatic test_step_err();
        apply_reset();
        samp(4'd6);
        samp(4'd7);
        samp(4'd12);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err, err_count} !== {5'b00001, 8'd1}) begin
            n_fail++;
            $display("FAIL steperr_jump got=%b/%0d exp=00001/1", {locked, dir, wrap, dir_change, step_err}, err_count);
        end
        samp(4'd13);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err, err_count} !== {5'b10000, 8'd1}) begin
            n_fail++;
            $display("FAIL steperr_relock got=%b/%0d exp=10000/1", {locked, dir, wrap, dir_change, step_err}, err_count);
        end
        samp(4'd14);
        n_checks++;
        if ({locked, dir, step_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL steperr_next got=%b exp=100", {locked, dir, step_err});
        end
        // illegal step while still training
        apply_reset();
        samp(4'd3);
        samp(4'd9);
        n_checks++;
        if ({locked, step_err, err_count} !== {2'b01, 8'd1}) begin
            n_fail++;
            $display("FAIL steperr_train got=%b/%0d exp=01/1", {locked, step_err}, err_count);
        end
    endtask

    task automatic test_hold();
        apply_reset();
        samp(4'd6);
        for (int i = 0; i < 5; i++) begin
            samp(4'd6);
            n_checks++;
            if ({locked, wrap, dir_change, step_err} !== 4'b0000) begin
                n_fail++;
                $display("FAIL hold_%0d got=%b exp=0000", i, {locked, wrap, dir_change, step_err});
            end
            count_in = 4'd11;
            @(posedge clk); #1;
        end
        samp(4'd7);
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL hold_lock got=%b exp=10000", {locked, dir, wrap, dir_change, step_err});
        end
        // disabled cycles with an illegal value present must be ignored
        count_in = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({locked, step_err, err_count} !== {2'b10, 8'd0}) begin
            n_fail++;
            $display("FAIL hold_disabled got=%b/%0d exp=10/0", {locked, step_err}, err_count);
        end
        samp(4'd8);
        n_checks++;
        if ({locked, step_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_prevkept got=%b exp=10", {locked, step_err});
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        samp(4'd1);
        samp(4'd2);
        samp(4'd9);
        samp(4'd3);
        samp(4'd11);
        samp(4'd12);
        n_checks++;
        if ({locked, err_count} !== {1'b1, 8'd3}) begin
            n_fail++;
            $display("FAIL arst_setup got=%b/%0d exp=1/3", locked, err_count);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({locked, dir, wrap, dir_change, step_err, err_count} !== {5'b00000, 8'd0}) begin
            n_fail++;
            $display("FAIL arst_immediate got=%b/%0d exp=00000/0", {locked, dir, wrap, dir_change, step_err}, err_count);
        end
        #1;
        rst = 1'b0;
        samp(4'd5);
        n_checks++;
        if ({locked, wrap, dir_change, step_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL arst_first got=%b exp=0000", {locked, wrap, dir_change, step_err});
        end
        samp(4'd6);
        n_checks++;
        if ({locked, dir} !== 2'b10) begin
            n_fail++;
            $display("FAIL arst_relock got=%b exp=10", {locked, dir});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] v;
        apply_reset();
        samp(4'd0);
        for (int i = 1; i <= 300; i++) begin
            v = (i % 2 == 1) ? 4'd8 : 4'd0;
            samp(v);
            if (i == 254) begin
                n_checks++;
                if ({step_err, err_count} !== {1'b1, 8'd254}) begin
                    n_fail++;
                    $display("FAIL sat_mid got=%b/%0d exp=1/254", step_err, err_count);
                end
            end
        end
        n_checks++;
        if ({step_err, err_count} !== {1'b1, 8'd255}) begin
            n_fail++;
            $display("FAIL sat_end got=%b/%0d exp=1/255", step_err, err_count);
        end
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; count_in = 4'd0;
        test_reset();
        test_lock_up();
        test_up_wrap();
        test_dir_change();
        test_step_err();
        test_hold();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
